// File: rtl/lc4_dmem_pkg.sv
// Shared definitions for the LC4 data-memory responder: device-page offsets,
// status bit positions and the device-page offset decoder.
package lc4_dmem_pkg;

  localparam logic [3:0] OFF_CON_STATUS   = 4'h0;
  localparam logic [3:0] OFF_CON_DATA     = 4'h2;
  localparam logic [3:0] OFF_LED          = 4'h4;
  localparam logic [3:0] OFF_SWITCH       = 4'h6;
  localparam logic [3:0] OFF_TMR_STATUS   = 4'h8;
  localparam logic [3:0] OFF_TMR_INTERVAL = 4'hA;

  localparam int CON_NOT_FULL_BIT = 15;
  localparam int CON_EMPTY_BIT    = 14;
  localparam int CON_OVF_BIT      = 13;
  localparam int TMR_EXP_BIT      = 15;

  typedef enum logic [2:0] {
    DEV_NONE,
    DEV_CON_STATUS,
    DEV_CON_DATA,
    DEV_LED,
    DEV_SWITCH,
    DEV_TMR_STATUS,
    DEV_TMR_INTERVAL
  } dev_sel_e;

  function automatic dev_sel_e decode_dev(input logic [3:0] off);
    dev_sel_e sel;
    case (off)
      OFF_CON_STATUS:   sel = DEV_CON_STATUS;
      OFF_CON_DATA:     sel = DEV_CON_DATA;
      OFF_LED:          sel = DEV_LED;
      OFF_SWITCH:       sel = DEV_SWITCH;
      OFF_TMR_STATUS:   sel = DEV_TMR_STATUS;
      OFF_TMR_INTERVAL: sel = DEV_TMR_INTERVAL;
      default:          sel = DEV_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lc4_dmem_responder_if.sv
// Core-side data-memory bus: gwe qualifier, address, store request/data and
// registered read data. The core is the master, the responder the slave.
interface lc4_dmem_responder_if;
  logic        gwe;
  logic [15:0] i_dmem_addr;
  logic        i_dmem_we;
  logic [15:0] i_dmem_towrite;
  logic [15:0] o_cur_dmem_data;

  modport master (
    output gwe, i_dmem_addr, i_dmem_we, i_dmem_towrite,
    input  o_cur_dmem_data
  );

  modport slave (
    input  gwe, i_dmem_addr, i_dmem_we, i_dmem_towrite,
    output o_cur_dmem_data
  );
endinterface

// File: rtl/lc4_tx_fifo.sv
// Console transmit FIFO: power-of-two depth, extra pointer bit separates full
// from empty. Head reads 0 while empty so the output is clean after reset.
module lc4_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lc4_dmem_responder.sv
// LC4 data-memory responder: word RAM plus device page (console FIFO, LEDs,
// switches, interval timer). Define LC4_DMEM_FAULT_EN for the sticky o_fault.
module lc4_dmem_responder
  import lc4_dmem_pkg::*;
#(
  parameter int          RAM_AW     = 13,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DEV_BASE   = 16'hFE00
) (
  input  logic                 clk,
  input  logic                 rst,
  lc4_dmem_responder_if.slave  bus,
  input  logic [7:0]           i_switch_data,
  output logic [7:0]           o_led_data,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_fault
);

  logic [15:0] ram_q [2**RAM_AW];
  logic [15:0] ram_rd_q;
  logic        sel_ram_q, sel_ram_d;
  logic [15:0] dev_rd_q, dev_rd_d;
  logic [7:0]  led_q, led_d;
  logic        ovf_q, ovf_d;
  logic [15:0] tmr_int_q, tmr_int_d;
  logic [15:0] tmr_cnt_q, tmr_cnt_d;
  logic        tmr_exp_q, tmr_exp_d;

  logic        is_ram;
  logic        is_dev;
  dev_sel_e    dev;
  logic        wr;
  logic        rd;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tmr_expire;

  lc4_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.i_dmem_towrite[7:0]),
    .pop   (fifo_pop),
    .dout  (o_tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_tx_valid          = !fifo_empty;
  assign fifo_pop            = o_tx_valid && i_tx_ready;
  assign o_led_data          = led_q;
  assign bus.o_cur_dmem_data = sel_ram_q ? ram_rd_q : dev_rd_q;

  always_comb begin
    is_ram = ((bus.i_dmem_addr >> RAM_AW) == 16'd0);
    is_dev = (bus.i_dmem_addr[15:4] == DEV_BASE[15:4]);
    dev    = is_dev ? decode_dev(bus.i_dmem_addr[3:0]) : DEV_NONE;
    wr     = bus.gwe && bus.i_dmem_we;
    rd     = bus.gwe && !bus.i_dmem_we;
  end

  // Read mux and architectural updates; "full" is the pre-pop view.
  always_comb begin
    sel_ram_d  = is_ram;
    dev_rd_d   = '0;
    led_d      = led_q;
    ovf_d      = ovf_q;
    tmr_int_d  = tmr_int_q;
    tmr_cnt_d  = tmr_cnt_q;
    tmr_exp_d  = tmr_exp_q;
    tmr_expire = 1'b0;
    fifo_push  = 1'b0;

    case (dev)
      DEV_CON_STATUS: begin
        dev_rd_d[CON_NOT_FULL_BIT] = !fifo_full;
        dev_rd_d[CON_EMPTY_BIT]    = fifo_empty;
        dev_rd_d[CON_OVF_BIT]      = ovf_q;
      end
      DEV_LED:          dev_rd_d = {8'h00, led_q};
      DEV_SWITCH:       dev_rd_d = {8'h00, i_switch_data};
      DEV_TMR_STATUS:   dev_rd_d[TMR_EXP_BIT] = tmr_exp_q;
      DEV_TMR_INTERVAL: dev_rd_d = tmr_int_q;
      default:          dev_rd_d = '0;
    endcase

    if (wr && dev == DEV_CON_DATA) begin
      if (fifo_full) ovf_d = 1'b1;
      else           fifo_push = 1'b1;
    end
    if (rd && dev == DEV_CON_STATUS) ovf_d = 1'b0;

    if (wr && dev == DEV_LED) led_d = bus.i_dmem_towrite[7:0];

    if (wr && dev == DEV_TMR_INTERVAL) begin
      tmr_int_d = bus.i_dmem_towrite;
      tmr_cnt_d = bus.i_dmem_towrite;
    end else if (bus.gwe && tmr_int_q != 16'd0) begin
      if (tmr_cnt_q <= 16'd1) begin
        tmr_cnt_d  = tmr_int_q;
        tmr_expire = 1'b1;
      end else begin
        tmr_cnt_d  = tmr_cnt_q - 16'd1;
      end
    end
    // Clear first so a coincident expiry keeps the bit set.
    if (rd && dev == DEV_TMR_STATUS) tmr_exp_d = 1'b0;
    if (tmr_expire)                  tmr_exp_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ram_q <= 1'b0;
      dev_rd_q  <= '0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
      tmr_int_q <= '0;
      tmr_cnt_q <= '0;
      tmr_exp_q <= 1'b0;
    end else begin
      sel_ram_q <= sel_ram_d;
      dev_rd_q  <= dev_rd_d;
      led_q     <= led_d;
      ovf_q     <= ovf_d;
      tmr_int_q <= tmr_int_d;
      tmr_cnt_q <= tmr_cnt_d;
      tmr_exp_q <= tmr_exp_d;
    end
  end

  // RAM contents are not reset; the read port runs every cycle.
  always_ff @(posedge clk) begin
    ram_rd_q <= ram_q[bus.i_dmem_addr[RAM_AW-1:0]];
    if (wr && is_ram) ram_q[bus.i_dmem_addr[RAM_AW-1:0]] <= bus.i_dmem_towrite;
  end

`ifdef LC4_DMEM_FAULT_EN
  logic fault_q, fault_d;
  logic bad_store;
  logic bad_load;

  always_comb begin
    bad_store = wr && (dev == DEV_CON_STATUS || dev == DEV_SWITCH ||
                       dev == DEV_TMR_STATUS || (!is_ram && dev == DEV_NONE));
    bad_load  = rd && (dev == DEV_CON_DATA || (!is_ram && dev == DEV_NONE));
    fault_d   = fault_q || bad_store || bad_load;
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_lc4_dmem_responder.sv
// Directed bench for lc4_dmem_responder: RAM, console FIFO, LED/switch,
// interval timer, reset behaviour and the optional sticky fault.
module tb_lc4_dmem_responder;
  import lc4_dmem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_switch_data;
  logic [7:0] o_led_data;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_fault;

  int errors = 0;
  int checks = 0;

  lc4_dmem_responder_if bus ();

  lc4_dmem_responder #(
    .RAM_AW     (13),
    .FIFO_DEPTH (8),
    .DEV_BASE   (16'hFE00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .i_switch_data (i_switch_data),
    .o_led_data    (o_led_data),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_fault       (o_fault)
  );

  always #5 clk = ~clk;

`ifdef LC4_DMEM_FAULT_EN
  localparam logic [15:0] FAULT_EXP = 16'd1;
`else
  localparam logic [15:0] FAULT_EXP = 16'd0;
`endif

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One clock edge with the given bus values; returns #1 after the edge.
  task automatic bus_cycle(input logic g, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.gwe            = g;
    bus.i_dmem_we      = we;
    bus.i_dmem_addr    = a;
    bus.i_dmem_towrite = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_switch_data = 8'h00;
    i_tx_ready = 1'b0;
    bus_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_val("rst_rdata", bus.o_cur_dmem_data, 16'h0000);
    check_val("rst_led", {8'h00, o_led_data}, 16'h0000);
    check_val("rst_txvalid", {15'h0, o_tx_valid}, 16'h0000);
    check_val("rst_txdata", {8'h00, o_tx_data}, 16'h0000);
    check_val("rst_fault", {15'h0, o_fault}, 16'h0000);
    rst = 1'b0;

    // RAM store/load, gwe qualification, top word and first unmapped word
    bus_cycle(1'b1, 1'b1, 16'h1000, 16'h1234);
    bus_cycle(1'b1, 1'b0, 16'h1000, 16'h0000);
    check_val("ram_load", bus.o_cur_dmem_data, 16'h1234);
    bus_cycle(1'b0, 1'b1, 16'h1000, 16'h5555);
    bus_cycle(1'b1, 1'b0, 16'h1000, 16'h0000);
    check_val("ram_nogwe", bus.o_cur_dmem_data, 16'h1234);
    bus_cycle(1'b1, 1'b1, 16'h1FFF, 16'hBEEF);
    bus_cycle(1'b1, 1'b0, 16'h1FFF, 16'h0000);
    check_val("ram_top", bus.o_cur_dmem_data, 16'hBEEF);
    bus_cycle(1'b1, 1'b1, 16'h2000, 16'h7777);
    check_val("unmapped_store_fault", {15'h0, o_fault}, FAULT_EXP);
    bus_cycle(1'b1, 1'b0, 16'h2000, 16'h0000);
    check_val("unmapped_read", bus.o_cur_dmem_data, 16'h0000);
    bus_cycle(1'b0, 1'b0, 16'hFE0C, 16'h0000);
    check_val("unmapped_dev_read", bus.o_cur_dmem_data, 16'h0000);

    // LED and switches
    bus_cycle(1'b1, 1'b1, 16'hFE04, 16'hABCD);
    check_val("led_out", {8'h00, o_led_data}, 16'h00CD);
    bus_cycle(1'b1, 1'b0, 16'hFE04, 16'h0000);
    check_val("led_read", bus.o_cur_dmem_data, 16'h00CD);
    i_switch_data = 8'h5A;
    bus_cycle(1'b0, 1'b0, 16'hFE06, 16'h0000);
    check_val("switch_read", bus.o_cur_dmem_data, 16'h005A);

    // Console FIFO overflow, read-clear and drain order
    for (int i = 0; i < 9; i++) bus_cycle(1'b1, 1'b1, 16'hFE02, 16'h0041 + 16'(i));
    check_val("fifo_valid", {15'h0, o_tx_valid}, 16'h0001);
    bus_cycle(1'b1, 1'b0, 16'hFE00, 16'h0000);
    check_val("con_status_ovf", bus.o_cur_dmem_data, 16'h2000);
    bus_cycle(1'b1, 1'b0, 16'hFE00, 16'h0000);
    check_val("con_status_clr", bus.o_cur_dmem_data, 16'h0000);
    i_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("drain_%0d", i), {8'h00, o_tx_data}, 16'h0041 + 16'(i));
      bus_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    check_val("drain_empty", {15'h0, o_tx_valid}, 16'h0000);
    i_tx_ready = 1'b0;
    bus_cycle(1'b1, 1'b0, 16'hFE00, 16'h0000);
    check_val("con_status_empty", bus.o_cur_dmem_data, 16'hC000);

    // Interval timer: period 3, read-clear, and set-wins coincidence
    bus_cycle(1'b1, 1'b1, 16'hFE0A, 16'h0003);
    bus_cycle(1'b0, 1'b0, 16'hFE0A, 16'h0000);
    check_val("tmr_interval", bus.o_cur_dmem_data, 16'h0003);
    for (int i = 0; i < 3; i++) bus_cycle(1'b1, 1'b0, 16'h0000, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_exp1", bus.o_cur_dmem_data, 16'h8000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_clr1", bus.o_cur_dmem_data, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_coincide", bus.o_cur_dmem_data, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_set_wins", bus.o_cur_dmem_data, 16'h8000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_clr2", bus.o_cur_dmem_data, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_clr3", bus.o_cur_dmem_data, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_exp3", bus.o_cur_dmem_data, 16'h8000);
    bus_cycle(1'b1, 1'b1, 16'hFE0A, 16'h0000);
    for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 16'hFE08, 16'h0000);
    check_val("tmr_halted", bus.o_cur_dmem_data, 16'h0000);

    // Reset with bytes queued and LEDs lit
    for (int i = 0; i < 3; i++) bus_cycle(1'b1, 1'b1, 16'hFE02, 16'h0061 + 16'(i));
    bus_cycle(1'b1, 1'b1, 16'hFE04, 16'h00FF);
    check_val("pre_rst_valid", {15'h0, o_tx_valid}, 16'h0001);
    check_val("pre_rst_led", {8'h00, o_led_data}, 16'h00FF);
    rst = 1'b1;
    bus_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    check_val("post_rst_valid", {15'h0, o_tx_valid}, 16'h0000);
    check_val("post_rst_led", {8'h00, o_led_data}, 16'h0000);
    check_val("post_rst_fault", {15'h0, o_fault}, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hFE00, 16'h0000);
    check_val("post_rst_status", bus.o_cur_dmem_data, 16'hC000);

    // Store to read-only switch register: ignored, sticky fault when enabled
    bus_cycle(1'b1, 1'b1, 16'hFE06, 16'h1234);
    check_val("ro_store_fault", {15'h0, o_fault}, FAULT_EXP);
    bus_cycle(1'b1, 1'b0, 16'hFE06, 16'h0000);
    check_val("ro_store_ignored", bus.o_cur_dmem_data, 16'h005A);
    bus_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_val("fault_sticky", {15'h0, o_fault}, FAULT_EXP);
    rst = 1'b1;
    bus_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    check_val("fault_rst", {15'h0, o_fault}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
